mod_reduce: RTL and testbench

Pipelined Barrett modular reduction stage placed directly downstream of the registered 22×22 multiplier in the prime-field butterfly datapath. It takes the 44-bit product and returns the product modulo P as a 22-bit field element, four cycles later. A valid flag and an index sideband travel with each sample. The block streams one sample per cycle with no backpressure.

---
 rtl/mod_reduce.sv | 112 +++++++++++
 tb/tb_mod_reduce.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mod_reduce.sv
// Four-stage pipelined Barrett reduction of a 2k-bit product modulo P.
// Optional input range checker enabled by defining MOD_REDUCE_RANGE_CHK_EN.
module mod_reduce #(
  parameter int DATA_WIDTH = 22,
  parameter int P          = 4194301,
  parameter int MU         = 4194307,
  parameter int IDX_WIDTH  = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [2*DATA_WIDTH-1:0] product_in,
  input  logic [IDX_WIDTH-1:0]    idx_in,
  output logic                    out_valid,
  output logic [DATA_WIDTH-1:0]   residue_out,
  output logic [IDX_WIDTH-1:0]    idx_out,
  output logic                    range_err
);

  localparam int K   = DATA_WIDTH;
  localparam int XW  = 2 * K;
  localparam int QW  = K + 1;
  localparam int MW  = 2 * QW;
  localparam int QPW = XW + 1;
  localparam int RW  = K + 2;

  localparam logic [MW-1:0]  MU_W = MW'(MU);
  localparam logic [QPW-1:0] P_QP = QPW'(P);
  localparam logic [RW-1:0]  P1_R = RW'(P);
  localparam logic [RW-1:0]  P2_R = RW'(2 * P);

  logic [QW-1:0]        q1_d;
  logic [QW-1:0]        q2_d;
  logic [K-1:0]         residue_d;

  logic [MW-1:0]        m1_q;
  logic [XW-1:0]        x1_q, x2_q;
  logic [QPW-1:0]       qp2_q;
  logic [RW-1:0]        r3_q;
  logic [IDX_WIDTH-1:0] idx1_q, idx2_q, idx3_q, idx_out_q;
  logic                 v1_q, v2_q, v3_q, out_valid_q;
  logic [K-1:0]         residue_q;

  assign q1_d = product_in[XW-1:K-1];
  assign q2_d = QW'(m1_q >> (K + 1));

  // r < 3P, so at most two conditional subtractions bring it into [0, P-1].
  always_comb begin
    residue_d = K'(r3_q);
    if (r3_q >= P2_R)      residue_d = K'(r3_q - P2_R);
    else if (r3_q >= P1_R) residue_d = K'(r3_q - P1_R);
  end

  // NOTE: the arithmetic pipeline is not reset; its contents are qualified
  // by the valid chain, so leaving it unreset saves reset routing for free.
  always_ff @(posedge clk) begin
    m1_q   <= MW'(q1_d) * MU_W;
    x1_q   <= product_in;
    idx1_q <= idx_in;
    qp2_q  <= QPW'(q2_d) * P_QP;
    x2_q   <= x1_q;
    idx2_q <= idx1_q;
    r3_q   <= RW'(QPW'(x2_q) - qp2_q);
    idx3_q <= idx2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_valid_q <= 1'b0;
      residue_q   <= '0;
      idx_out_q   <= '0;
    end else begin
      v1_q        <= in_valid;
      v2_q        <= v1_q;
      v3_q        <= v2_q;
      out_valid_q <= v3_q;
      residue_q   <= residue_d;
      idx_out_q   <= idx3_q;
    end
  end

  assign out_valid   = out_valid_q;
  assign residue_out = residue_q;
  assign idx_out     = idx_out_q;

`ifdef MOD_REDUCE_RANGE_CHK_EN
  localparam logic [QPW-1:0] P_SQ = P_QP * P_QP;

  logic err1_q, err2_q, err3_q;
  logic range_err_q;

  always_ff @(posedge clk) begin
    err1_q <= in_valid & ({1'b0, product_in} >= P_SQ);
    err2_q <= err1_q;
    err3_q <= err2_q;
  end

  // Sticky until reset; set on the same edge the offending sample emerges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              range_err_q <= 1'b0;
    else if (v3_q && err3_q) range_err_q <= 1'b1;
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_mod_reduce.sv
// Self-checking bench for mod_reduce: scoreboard of expected residue, index
// and output cycle; honours MOD_REDUCE_RANGE_CHK_EN when defined.
module tb_mod_reduce;

  localparam int K  = 22;
  localparam int P  = 4194301;
  localparam int IW = 14;
  localparam longint unsigned P_L  = 64'(P);
  localparam longint unsigned P_SQ = P_L * P_L;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic [2*K-1:0]  product_in = '0;
  logic [IW-1:0]   idx_in = '0;
  logic            out_valid;
  logic [K-1:0]    residue_out;
  logic [IW-1:0]   idx_out;
  logic            range_err;

  mod_reduce #(
    .DATA_WIDTH(K),
    .P(P),
    .MU(4194307),
    .IDX_WIDTH(IW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .product_in(product_in),
    .idx_in(idx_in),
    .out_valid(out_valid),
    .residue_out(residue_out),
    .idx_out(idx_out),
    .range_err(range_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [K-1:0]  res;
    logic [IW-1:0] idx;
    int            due;
    bit            oor;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  bit   exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [2*K-1:0] x, input logic [IW-1:0] idx);
    exp_t e;
    longint unsigned xl;
    @(negedge clk);
    in_valid   = 1'b1;
    product_in = x;
    idx_in     = idx;
    xl    = 64'(x);
    e.res = K'(xl % P_L);
    e.idx = idx;
    e.due = cyc + 4;
`ifdef MOD_REDUCE_RANGE_CHK_EN
    e.oor = (xl >= P_SQ);
`else
    e.oor = 1'b0;
`endif
    sb.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid   = 1'b0;
    product_in = {$urandom, $urandom};
    idx_in     = IW'($urandom);
  endtask

  // Output monitor: every valid output must match the head of the scoreboard
  // on the exact cycle it is due; a due entry with no out_valid is a miss.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 64'd1, 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("latency", 64'(cyc), 64'(mon_e.due));
          if (!mon_e.oor) check("residue", 64'(residue_out), 64'(mon_e.res));
          check("idx", 64'(idx_out), 64'(mon_e.idx));
          if (mon_e.oor) exp_err = 1'b1;
          check("range_err", 64'(range_err), 64'(exp_err));
        end
      end else begin
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          check("missing_valid", 64'd0, 64'd1);
          void'(sb.pop_front());
        end
        check("range_err_idle", 64'(range_err), 64'(exp_err));
      end
    end
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_residue", 64'(residue_out), 64'd0);
    check("rst_idx", 64'(idx_out), 64'd0);
    check("rst_range_err", 64'(range_err), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();

    // Directed corner values, isolated.
    send(44'd0, 14'd1);            repeat (5) idle();
    send(44'(P), 14'd2);           repeat (5) idle();
    send(44'(P - 1), 14'd3);       repeat (5) idle();
    send(44'd17592160878600, 14'd4); repeat (5) idle();
`ifndef MOD_REDUCE_RANGE_CHK_EN
    send(44'd17592186044407, 14'd5); repeat (5) idle();
`endif

    // Bubble pattern 1,0,1,1,0,0,1.
    send(44'd123456789, 14'd10);
    idle();
    send(44'd987654321012, 14'd11);
    send(44'(2 * P + 7), 14'd12);
    idle();
    idle();
    send(44'(3 * P_L - 1), 14'd13);
    repeat (6) idle();

    // Back-to-back random stream.
    for (int i = 0; i < 10000; i++) begin
      longint unsigned r;
      r = {$urandom, $urandom};
      send(44'(r % P_SQ), IW'($urandom));
    end
    repeat (6) idle();

    // Reset mid-stream discards in-flight samples.
    send(44'd1000001, 14'd100);
    send(44'd2000002, 14'd101);
    send(44'd3000003, 14'd102);
    idle();
    #2;
    rst_n = 1'b0;
    sb.delete();
    exp_err = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_residue", 64'(residue_out), 64'd0);
    check("midrst_idx", 64'(idx_out), 64'd0);
    check("midrst_range_err", 64'(range_err), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) idle();
    send(44'd17592160878600, 14'd200);
    repeat (6) idle();

`ifdef MOD_REDUCE_RANGE_CHK_EN
    // Out-of-range sample raises a sticky flag at its output cycle.
    send(44'hFFF_FFFF_FFFF, 14'd300);
    send(44'd5, 14'd301);
    send(44'd17592186044407, 14'd302);
    send(44'(P + 9), 14'd303);
    repeat (8) idle();
    check("range_err_held", 64'(range_err), 64'd1);
`else
    send(44'(P_SQ - 1), 14'd300);
    send(44'd5, 14'd301);
    repeat (8) idle();
    check("range_err_tied", 64'(range_err), 64'd0);
`endif

    // Bounded drain.
    for (int i = 0; i < 20 && sb.size() > 0; i++) idle();
    check("drain_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
